mips_mem_arbiter: RTL

- Shares the single 128-bit line-wide memory port between the instruction cache (port 0, read-only) and the data cache (port 1, read/write-back).
- Sits between both mips_cache_128 instances and main memory.
- Serialises line transactions, applies round-robin priority, and returns each line to the requester that issued it.
- Has a watchdog that aborts a memory transaction that never completes.

---
 rtl/mips_mem_arbiter_if.sv | 48 ++++
 rtl/mips_mem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Line-wide memory arbiter bus: icache request port, dcache request port,
// shared memory port and arbiter status, with arbiter (slave) and environment (master) views.
interface mips_mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 128
);
   logic                  i_valid;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ready;
   logic [LINE_WIDTH-1:0] i_rdata;

   logic                  d_valid;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic                  d_ready;
   logic [LINE_WIDTH-1:0] d_rdata;

   logic                  mem_valid;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic                  mem_ready;
   logic [LINE_WIDTH-1:0] mem_rdata;

   logic                  grant_d;
   logic                  timeout_err;

   modport slave (
      input  i_valid, i_addr,
      output i_ready, i_rdata,
      input  d_valid, d_we, d_addr, d_wdata,
      output d_ready, d_rdata,
      output mem_valid, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata,
      output grant_d, timeout_err
   );

   modport master (
      output i_valid, i_addr,
      input  i_ready, i_rdata,
      output d_valid, d_we, d_addr, d_wdata,
      input  d_ready, d_rdata,
      input  mem_valid, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata,
      input  grant_d, timeout_err
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between icache and dcache,
// with a watchdog that aborts memory transactions that never complete.
module mips_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned LINE_WIDTH     = 128,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic               clock,
   input logic               reset,
   mips_mem_arbiter_if.slave bus
);
   localparam int unsigned            CNT_WIDTH = 16;
   localparam logic [CNT_WIDTH-1:0]   WD_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  last_grant, last_grant_nxt;
   logic                  grant_d_q, grant_d_nxt;
   logic                  mem_valid_q, mem_valid_nxt;
   logic                  mem_we_q, mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_nxt;
   logic                  i_ready_q, i_ready_nxt;
   logic                  d_ready_q, d_ready_nxt;
   logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_nxt;
   logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_nxt;
   logic                  timeout_q, timeout_nxt;
   logic [CNT_WIDTH-1:0]  wd_cnt, wd_cnt_nxt;
   logic                  pick_d;
   logic                  wd_expire;

   // dcache wins when alone, or on a tie when icache had the last grant
   assign pick_d    = bus.d_valid & (~bus.i_valid | ~last_grant);
   assign wd_expire = (wd_cnt == WD_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_d_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         timeout_q   <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         grant_d_q   <= grant_d_nxt;
         mem_valid_q <= mem_valid_nxt;
         mem_we_q    <= mem_we_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_wdata_q <= mem_wdata_nxt;
         i_ready_q   <= i_ready_nxt;
         d_ready_q   <= d_ready_nxt;
         i_rdata_q   <= i_rdata_nxt;
         d_rdata_q   <= d_rdata_nxt;
         timeout_q   <= timeout_nxt;
         wd_cnt      <= wd_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.i_valid | bus.d_valid) state_nxt = ISSUE;
         ISSUE:   if (bus.mem_ready | wd_expire) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      last_grant_nxt = last_grant;
      grant_d_nxt    = grant_d_q;
      mem_valid_nxt  = mem_valid_q;
      mem_we_nxt     = mem_we_q;
      mem_addr_nxt   = mem_addr_q;
      mem_wdata_nxt  = mem_wdata_q;
      i_ready_nxt    = 1'b0;
      d_ready_nxt    = 1'b0;
      i_rdata_nxt    = i_rdata_q;
      d_rdata_nxt    = d_rdata_q;
      timeout_nxt    = timeout_q;
      wd_cnt_nxt     = wd_cnt;
      unique case (state)
         IDLE: begin
            if (bus.i_valid | bus.d_valid) begin
               last_grant_nxt = pick_d;
               grant_d_nxt    = pick_d;
               mem_valid_nxt  = 1'b1;
               mem_we_nxt     = pick_d & bus.d_we;
               mem_addr_nxt   = pick_d ? bus.d_addr : bus.i_addr;
               if (pick_d) mem_wdata_nxt = bus.d_wdata;
               wd_cnt_nxt     = '0;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               if (grant_d_q) d_rdata_nxt = bus.mem_rdata;
               else           i_rdata_nxt = bus.mem_rdata;
            end else if (wd_expire) begin
               timeout_nxt = 1'b1;
            end else begin
               wd_cnt_nxt = wd_cnt + CNT_WIDTH'(1);
            end
            // leaving ISSUE: end the memory request and pulse the owner's ready in RESP
            if (bus.mem_ready | wd_expire) begin
               mem_valid_nxt = 1'b0;
               mem_we_nxt    = 1'b0;
               i_ready_nxt   = ~grant_d_q;
               d_ready_nxt   = grant_d_q;
            end
         end
         default: ;
      endcase
   end

   assign bus.i_ready     = i_ready_q;
   assign bus.i_rdata     = i_rdata_q;
   assign bus.d_ready     = d_ready_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.mem_valid   = mem_valid_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.grant_d     = grant_d_q;
   assign bus.timeout_err = timeout_q;
endmodule
